// File: rtl/chord_pkg.sv
// Shared CHORD definitions: Q7.8 result format, output word layout and the
// saturating negate used when the ±90° input fold is undone.
package chord_pkg;

    localparam int OUTPUT_WIDTH = 16;
    localparam int INT_BITS     = 7;
    localparam int FRAC_BITS    = 8;
    localparam int WORD_WIDTH   = 32;

    localparam int SIN_MSB = 31;
    localparam int SIN_LSB = 16;
    localparam int COS_MSB = 15;
    localparam int COS_LSB = 0;

    localparam logic [OUTPUT_WIDTH-1:0] Q_MAX     = 16'h7FFF;
    localparam logic [OUTPUT_WIDTH-1:0] Q_MIN     = 16'h8000;
    localparam logic [OUTPUT_WIDTH-1:0] ANGLE_P90 = 16'(90 << FRAC_BITS);

    // Two's-complement negate; the most negative code has no positive
    // counterpart, so it clamps to the largest positive value.
    function automatic logic [OUTPUT_WIDTH-1:0] sat_neg(input logic [OUTPUT_WIDTH-1:0] v);
        logic [OUTPUT_WIDTH-1:0] r;
        if (v == Q_MIN) begin
            r = Q_MAX;
        end else begin
            r = (~v) + 16'h0001;
        end
        return r;
    endfunction

endpackage

// File: rtl/chord_out_fifo.sv
// Generic first-word-fall-through FIFO with occupancy and a sticky drop flag.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module chord_out_fifo #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int LEVEL_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop_ready,
    output logic [WIDTH-1:0]       head,
    output logic                   head_valid,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]       mem_r [DEPTH];
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [LEVEL_WIDTH-1:0] level_r;
    logic                   overflow_r;

    logic empty_s;
    logic full_s;
    logic pop_s;
    logic push_ok_s;
    logic drop_s;

    // Handshake decode from registered occupancy only.
    always_comb begin
        empty_s   = (level_r == {LEVEL_WIDTH{1'b0}});
        full_s    = (level_r == LEVEL_WIDTH'(DEPTH));
        pop_s     = (!empty_s) && pop_ready;
        push_ok_s = push && ((!full_s) || pop_s);
        drop_s    = push && full_s && (!pop_s);
    end

    // Storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            level_r    <= {LEVEL_WIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   level_r <= level_r + LEVEL_WIDTH'(1);
                2'b01:   level_r <= level_r - LEVEL_WIDTH'(1);
                default: level_r <= level_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign head       = mem_r[rd_ptr_r];
    assign head_valid = !empty_s;
    assign level      = level_r;
    assign overflow   = overflow_r;

endmodule

// File: rtl/interface_output.sv
// CHORD output adapter: undoes the ±90° input fold, packs each result into a
// 32-bit word in a post-process register, and buffers words for a valid/ready consumer.
module interface_output #(
    parameter int OUTPUT_WIDTH = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int LEVEL_WIDTH  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OUTPUT_WIDTH-1:0] x_out,
    input  logic [OUTPUT_WIDTH-1:0] y_out,
    input  logic [OUTPUT_WIDTH-1:0] degree_out,
    input  logic                    flip_out,
    input  logic                    fold_neg_out,
    input  logic                    arctan_en_out,
    input  logic                    valid_out,
    output logic [31:0]             out_interface,
    output logic                    valid_out_interface,
    input  logic                    ready_in_interface,
    output logic [LEVEL_WIDTH-1:0]  fifo_level,
    output logic                    overflow
);

    import chord_pkg::*;

    logic [OUTPUT_WIDTH-1:0] sin_s;
    logic [OUTPUT_WIDTH-1:0] cos_s;
    logic [WORD_WIDTH-1:0]   word_s;
    logic [WORD_WIDTH-1:0]   s1_word_r;
    logic                    s1_valid_r;

    // Unfold: theta = phi + 90 rotates (c,s) to (-s,c); theta = phi - 90 to (s,-c).
    always_comb begin
        sin_s  = y_out;
        cos_s  = x_out;
        word_s = {WORD_WIDTH{1'b0}};
        case ({flip_out, fold_neg_out})
            2'b10: begin
                cos_s = sat_neg(y_out);
                sin_s = x_out;
            end
            2'b11: begin
                cos_s = y_out;
                sin_s = sat_neg(x_out);
            end
            default: begin
                sin_s = y_out;
                cos_s = x_out;
            end
        endcase
        if (arctan_en_out) begin
            word_s = {{(WORD_WIDTH-OUTPUT_WIDTH){1'b0}}, degree_out};
        end else begin
            word_s[SIN_MSB:SIN_LSB] = sin_s;
            word_s[COS_MSB:COS_LSB] = cos_s;
        end
    end

    // Post-process register; inputs seen during reset are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_word_r  <= {WORD_WIDTH{1'b0}};
        end else begin
            s1_valid_r <= valid_out;
            if (valid_out) begin
                s1_word_r <= word_s;
            end
        end
    end

    chord_out_fifo #(
        .WIDTH       (WORD_WIDTH),
        .DEPTH       (FIFO_DEPTH),
        .LEVEL_WIDTH (LEVEL_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (s1_valid_r),
        .push_data  (s1_word_r),
        .pop_ready  (ready_in_interface),
        .head       (out_interface),
        .head_valid (valid_out_interface),
        .level      (fifo_level),
        .overflow   (overflow)
    );

endmodule
